// File: rtl/clkgate_pkg.sv
// ---------------------------------------------------------------------------
// clkgate_pkg
//   Shared definitions for the clock-gate enable controller:
//   - clkgate_state_e : FSM state type (OFF, WAKE, ON, IDLE_WAIT), 2-bit code
//   - S_* constants   : the same codes as plain logic constants. The FSM
//                       register is declared as plain logic, so the
//                       controller uses these constants to name its states.
//   - clog2_int / timer_width : size the shared wake/idle timer
// ---------------------------------------------------------------------------
package clkgate_pkg;

  typedef enum logic [1:0] {
    ST_OFF       = 2'd0,
    ST_WAKE      = 2'd1,
    ST_ON        = 2'd2,
    ST_IDLE_WAIT = 2'd3
  } clkgate_state_e;

  localparam logic [1:0] S_OFF       = 2'd0;
  localparam logic [1:0] S_WAKE      = 2'd1;
  localparam logic [1:0] S_ON        = 2'd2;
  localparam logic [1:0] S_IDLE_WAIT = 2'd3;

  // Smallest width such that (1 << width) >= value.
  function automatic int clog2_int(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) width++;
    return width;
  endfunction

  // The timer only ever holds WAKE_CYCLES-1 or IDLE_CYCLES-1, so
  // clog2(max) bits are enough. A minimum of one bit keeps the vector legal
  // when both delays are 1.
  function automatic int timer_width(input int wake_cycles, input int idle_cycles);
    int max_cycles;
    int width;
    max_cycles = (wake_cycles > idle_cycles) ? wake_cycles : idle_cycles;
    width = clog2_int(max_cycles);
    return (width < 1) ? 1 : width;
  endfunction

endpackage

// File: rtl/clkgate_downcnt.sv
// ---------------------------------------------------------------------------
// clkgate_downcnt
//   Loadable down-counter with a zero flag. It is the shared wake/idle timer
//   of clkgate_ctrl. A load takes priority over a decrement. A decrement at
//   zero leaves the count at zero, so the counter never wraps.
// Ports
//   clk      in  1  free-running clock
//   rst      in  1  asynchronous active-high reset (count -> 0)
//   load     in  1  load load_val on the next rising edge
//   load_val in  W  value to load
//   dec      in  1  decrement on the next rising edge (when not loading)
//   zero     out 1  count is zero (decoded from the count flops)
// ---------------------------------------------------------------------------
module clkgate_downcnt
  import clkgate_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/clkgate_ctrl.sv
// ---------------------------------------------------------------------------
// clkgate_ctrl
//   Enable-side controller for the latch-based clock gate. It turns requester
//   wake requests, busy flags and a debug override into a registered,
//   glitch-free 'gate' enable.
//   - Each requester uses a four-phase req/ack handshake.
//   - A requester is acked only after gate has been high for WAKE_CYCLES.
//   - After the last activity ends, gate stays high for IDLE_CYCLES
//     consecutive idle cycles before it drops.
//   Every output comes straight from a flop, so gate changes only on a rising
//   clk edge or on asynchronous reset.
// Ports
//   clk       in  1     free-running (always-on) clock
//   rst       in  1     asynchronous active-high reset
//   req       in  NREQ  per-requester wake request, held until ack
//   busy      in  NREQ  per-requester activity, keeps clock on, no handshake
//   force_on  in  1     debug override, keeps gate high while set
//   gate      out 1     registered enable to clkgate.gate
//   ack       out NREQ  per-requester ack, high only while the clock is stable
//   clk_on    out 1     status: controller is in ON or IDLE_WAIT
//   wake_cnt  out CNTW  saturating count of OFF->WAKE transitions
// ---------------------------------------------------------------------------
module clkgate_ctrl
  import clkgate_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int WAKE_CYCLES = 2,
  parameter int IDLE_CYCLES = 16,
  parameter int CNTW        = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] busy,
  input  logic            force_on,
  output logic            gate,
  output logic [NREQ-1:0] ack,
  output logic            clk_on,
  output logic [CNTW-1:0] wake_cnt
);

  localparam int TW = timer_width(WAKE_CYCLES, IDLE_CYCLES);
  localparam logic [TW-1:0] WAKE_LOAD = TW'(WAKE_CYCLES - 1);
  localparam logic [TW-1:0] IDLE_LOAD = TW'(IDLE_CYCLES - 1);

  logic [1:0]    state;
  logic [1:0]    next_state;
  logic          activity;
  logic          timer_load;
  logic [TW-1:0] timer_load_val;
  logic          timer_dec;
  logic          timer_zero;
  logic          next_clk_on;

  assign activity = (|req) | (|busy) | force_on;

  // One timer serves both phases, because WAKE and IDLE_WAIT never overlap.
  // It is loaded on the edge that enters the phase and counts down to zero.
  clkgate_downcnt #(
    .W (TW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_load_val),
    .dec      (timer_dec),
    .zero     (timer_zero)
  );

  // Next-state and timer control. WAKE always runs to completion, even if
  // activity goes away meanwhile. IDLE_WAIT returns straight to ON on any
  // activity, with no new wake delay. ON wins when activity arrives on the
  // same cycle the idle timer reaches zero.
  always_comb begin
    next_state     = state;
    timer_load     = 1'b0;
    timer_load_val = '0;
    timer_dec      = 1'b0;
    case (state)
      S_OFF: begin
        if (activity) begin
          next_state     = S_WAKE;
          timer_load     = 1'b1;
          timer_load_val = WAKE_LOAD;
        end
      end
      S_WAKE: begin
        if (timer_zero) begin
          next_state = S_ON;
        end else begin
          timer_dec = 1'b1;
        end
      end
      S_ON: begin
        if (!activity) begin
          next_state     = S_IDLE_WAIT;
          timer_load     = 1'b1;
          timer_load_val = IDLE_LOAD;
        end
      end
      S_IDLE_WAIT: begin
        if (activity) begin
          next_state = S_ON;
        end else if (timer_zero) begin
          next_state = S_OFF;
        end else begin
          timer_dec = 1'b1;
        end
      end
      default: begin
        next_state = S_OFF;
      end
    endcase
  end

  assign next_clk_on = (next_state == S_ON) || (next_state == S_IDLE_WAIT);

  // The outputs are registered from next_state, so they line up with the
  // state register. Acks follow req only while the clock is stable. This
  // includes the edge that enters ON, so a request raised during WAKE is
  // acked on that entry edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_OFF;
      gate   <= 1'b0;
      clk_on <= 1'b0;
      ack    <= '0;
    end else begin
      state  <= next_state;
      gate   <= (next_state != S_OFF);
      clk_on <= next_clk_on;
      ack    <= next_clk_on ? req : '0;
    end
  end

  // Count only the OFF->WAKE transition. Requests that arrive together join
  // the same wake, so they add one count. The counter holds at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wake_cnt <= '0;
    end else if ((state == S_OFF) && activity && (wake_cnt != '1)) begin
      wake_cnt <= wake_cnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_clkgate_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clkgate_ctrl
//   Self-checking bench for clkgate_ctrl. A behavioural model tracks
//   "clock requested", the remaining wake delay and the run of consecutive
//   idle samples, and is compared with the DUT on every falling edge.
//   Directed sequences pin the model with literal expectations, and a
//   randomized phase follows the req/ack protocol. A second instance with
//   CNTW=2 covers saturation of the wake counter.
// ---------------------------------------------------------------------------
module tb_clkgate_ctrl;

  localparam int NREQ    = 4;
  localparam int WAKE    = 2;
  localparam int IDLE    = 16;
  localparam int CNTW    = 16;
  localparam int MAX_CNT = (1 << CNTW) - 1;

  logic            clk;
  logic            rst;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] busy;
  logic            force_on;
  logic            gate;
  logic [NREQ-1:0] ack;
  logic            clk_on;
  logic [CNTW-1:0] wake_cnt;

  logic            sat_req;
  logic            sat_gate;
  logic            sat_ack;
  logic            sat_clk_on;
  logic [1:0]      sat_wake_cnt;

  int errors;
  int checks;
  logic cmp_en;

  clkgate_ctrl #(
    .NREQ        (NREQ),
    .WAKE_CYCLES (WAKE),
    .IDLE_CYCLES (IDLE),
    .CNTW        (CNTW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .busy     (busy),
    .force_on (force_on),
    .gate     (gate),
    .ack      (ack),
    .clk_on   (clk_on),
    .wake_cnt (wake_cnt)
  );

  clkgate_ctrl #(
    .NREQ        (1),
    .WAKE_CYCLES (1),
    .IDLE_CYCLES (1),
    .CNTW        (2)
  ) dut_sat (
    .clk      (clk),
    .rst      (rst),
    .req      (sat_req),
    .busy     (1'b0),
    .force_on (1'b0),
    .gate     (sat_gate),
    .ack      (sat_ack),
    .clk_on   (sat_clk_on),
    .wake_cnt (sat_wake_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference model.
  logic            tb_activity;
  logic            m_gate;
  logic            m_stable;
  int              m_wake_left;
  int              m_idle_run;
  logic [NREQ-1:0] m_ack;
  int              m_wake_cnt;

  assign tb_activity = (|req) || (|busy) || force_on;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_gate      <= 1'b0;
      m_stable    <= 1'b0;
      m_wake_left <= 0;
      m_idle_run  <= 0;
      m_ack       <= '0;
      m_wake_cnt  <= 0;
    end else if (!m_gate) begin
      m_ack <= '0;
      if (tb_activity) begin
        m_gate      <= 1'b1;
        m_wake_left <= WAKE;
        if (m_wake_cnt < MAX_CNT) m_wake_cnt <= m_wake_cnt + 1;
      end
    end else if (m_wake_left > 0) begin
      m_wake_left <= m_wake_left - 1;
      if (m_wake_left == 1) begin
        m_stable   <= 1'b1;
        m_ack      <= req;
        m_idle_run <= 0;
      end else begin
        m_ack <= '0;
      end
    end else begin
      m_ack <= req;
      if (tb_activity) begin
        m_idle_run <= 0;
      end else if (m_idle_run >= IDLE) begin
        m_gate     <= 1'b0;
        m_stable   <= 1'b0;
        m_ack      <= '0;
        m_idle_run <= 0;
      end else begin
        m_idle_run <= m_idle_run + 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [NREQ-1:0] b,
                               input logic f);
    req      = r;
    busy     = b;
    force_on = f;
  endtask

  task automatic stepCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Compare the DUT with the model on every falling edge outside reset.
  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      checkOutput("model_gate", 32'(gate), 32'(m_gate));
      checkOutput("model_clk_on", 32'(clk_on), 32'(m_stable));
      checkOutput("model_ack", 32'(ack), 32'(m_ack));
      checkOutput("model_wake_cnt", 32'(wake_cnt), 32'(m_wake_cnt));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [NREQ-1:0] nreq;
    logic [NREQ-1:0] nbusy;
    logic            nforce;
    logic            quiet;
    int              exp_sat;

    errors  = 0;
    checks  = 0;
    cmp_en  = 1'b0;
    rst     = 1'b1;
    sat_req = 1'b0;
    applyStimulus('0, '0, 1'b0);
    stepCycles(2);
    checkOutput("reset_gate", 32'(gate), 32'd0);
    checkOutput("reset_ack", 32'(ack), 32'd0);
    checkOutput("reset_clk_on", 32'(clk_on), 32'd0);
    checkOutput("reset_wake_cnt", 32'(wake_cnt), 32'd0);
    rst    = 1'b0;
    cmp_en = 1'b1;
    stepCycles(2);

    // Test 1: wake latency from req[0].
    $display("[TB] wake latency");
    applyStimulus(4'b0001, '0, 1'b0);
    stepCycles(1);
    checkOutput("t1_gate_e0", 32'(gate), 32'd1);
    checkOutput("t1_ack_e0", 32'(ack), 32'd0);
    checkOutput("t1_clk_on_e0", 32'(clk_on), 32'd0);
    checkOutput("t1_wake_cnt", 32'(wake_cnt), 32'd1);
    stepCycles(1);
    checkOutput("t1_ack_e1", 32'(ack), 32'd0);
    stepCycles(1);
    checkOutput("t1_ack_e2", 32'(ack), 32'b0001);
    checkOutput("t1_clk_on_e2", 32'(clk_on), 32'd1);

    // Test 2: release at e10, gate drops after e26.
    $display("[TB] idle shutdown");
    stepCycles(7);
    applyStimulus('0, '0, 1'b0);
    stepCycles(1);
    checkOutput("t2_ack_e10", 32'(ack), 32'd0);
    checkOutput("t2_gate_e10", 32'(gate), 32'd1);
    stepCycles(15);
    checkOutput("t2_gate_e25", 32'(gate), 32'd1);
    checkOutput("t2_clk_on_e25", 32'(clk_on), 32'd1);
    stepCycles(1);
    checkOutput("t2_gate_e26", 32'(gate), 32'd0);
    checkOutput("t2_clk_on_e26", 32'(clk_on), 32'd0);

    // Test 3: busy arrives on the final idle cycle.
    $display("[TB] busy on last idle cycle");
    applyStimulus('0, 4'b0001, 1'b0);
    stepCycles(3);
    checkOutput("t3_clk_on", 32'(clk_on), 32'd1);
    checkOutput("t3_wake_cnt", 32'(wake_cnt), 32'd2);
    applyStimulus('0, '0, 1'b0);
    stepCycles(16);
    checkOutput("t3_gate_before", 32'(gate), 32'd1);
    applyStimulus('0, 4'b0100, 1'b0);
    stepCycles(1);
    checkOutput("t3_gate_kept", 32'(gate), 32'd1);
    checkOutput("t3_clk_on_kept", 32'(clk_on), 32'd1);
    checkOutput("t3_wake_cnt_same", 32'(wake_cnt), 32'd2);
    applyStimulus('0, '0, 1'b0);
    stepCycles(16);
    checkOutput("t3_gate_restart", 32'(gate), 32'd1);
    stepCycles(1);
    checkOutput("t3_gate_off", 32'(gate), 32'd0);

    // Test 4: req during WAKE and req during ON.
    $display("[TB] late requests");
    applyStimulus(4'b0001, '0, 1'b0);
    stepCycles(1);
    applyStimulus(4'b0011, '0, 1'b0);
    stepCycles(1);
    checkOutput("t4_ack_wake", 32'(ack), 32'd0);
    stepCycles(1);
    checkOutput("t4_ack_on_entry", 32'(ack), 32'b0011);
    applyStimulus(4'b1011, '0, 1'b0);
    stepCycles(1);
    checkOutput("t4_ack_next", 32'(ack), 32'b1011);
    checkOutput("t4_wake_cnt", 32'(wake_cnt), 32'd3);
    applyStimulus('0, '0, 1'b0);
    stepCycles(20);
    checkOutput("t4_gate_off", 32'(gate), 32'd0);

    // Test 5: force_on alone.
    $display("[TB] force_on");
    applyStimulus('0, '0, 1'b1);
    stepCycles(3);
    checkOutput("t5_gate", 32'(gate), 32'd1);
    checkOutput("t5_ack", 32'(ack), 32'd0);
    stepCycles(5);
    applyStimulus('0, '0, 1'b0);
    stepCycles(16);
    checkOutput("t5_gate_hold", 32'(gate), 32'd1);
    stepCycles(1);
    checkOutput("t5_gate_off", 32'(gate), 32'd0);
    checkOutput("t5_wake_cnt", 32'(wake_cnt), 32'd4);

    // Randomized phase with periodic quiet windows so shutdowns happen.
    $display("[TB] random phase");
    for (int cyc = 0; cyc < 480; cyc++) begin
      quiet  = ((cyc % 80) >= 50);
      nreq   = req;
      nbusy  = '0;
      nforce = 1'b0;
      for (int b = 0; b < NREQ; b++) begin
        if (!req[b] && !quiet && ($urandom_range(0, 9) == 0)) nreq[b] = 1'b1;
        else if (req[b] && ack[b] && ($urandom_range(0, 2) == 0)) nreq[b] = 1'b0;
        nbusy[b] = !quiet && ($urandom_range(0, 11) == 0);
      end
      nforce = !quiet && ($urandom_range(0, 29) == 0);
      applyStimulus(nreq, nbusy, nforce);
      stepCycles(1);
    end
    applyStimulus('0, '0, 1'b0);
    stepCycles(22);

    // Test 6: asynchronous reset mid-WAKE and mid-ON.
    $display("[TB] async reset");
    applyStimulus(4'b0001, '0, 1'b0);
    stepCycles(1);
    checkOutput("t6_gate_wake", 32'(gate), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("t6_wake_gate", 32'(gate), 32'd0);
    checkOutput("t6_wake_ack", 32'(ack), 32'd0);
    checkOutput("t6_wake_clk_on", 32'(clk_on), 32'd0);
    stepCycles(1);
    rst = 1'b0;
    stepCycles(3);
    checkOutput("t6_on_ack", 32'(ack), 32'b0001);
    #2 rst = 1'b1;
    #1;
    checkOutput("t6_on_gate", 32'(gate), 32'd0);
    checkOutput("t6_on_ack_rst", 32'(ack), 32'd0);
    checkOutput("t6_on_clk_on", 32'(clk_on), 32'd0);
    checkOutput("t6_on_wake_cnt", 32'(wake_cnt), 32'd0);
    applyStimulus('0, '0, 1'b0);
    stepCycles(1);
    rst = 1'b0;
    stepCycles(2);

    // Saturating wake counter on the CNTW=2 instance.
    $display("[TB] wake counter saturation");
    for (int k = 1; k <= 5; k++) begin
      exp_sat = (k < 3) ? k : 3;
      sat_req = 1'b1;
      stepCycles(2);
      checkOutput("sat_ack", 32'(sat_ack), 32'd1);
      checkOutput("sat_clk_on", 32'(sat_clk_on), 32'd1);
      sat_req = 1'b0;
      stepCycles(3);
      checkOutput("sat_gate_off", 32'(sat_gate), 32'd0);
      checkOutput("sat_wake_cnt", 32'(sat_wake_cnt), 32'(exp_sat));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
